// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported synchronous-read memory between instruction fetch and the data port.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_LIMIT losses.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic [31:0] m_addr,
  output logic        m_re,
  output logic [3:0]  m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] resp_owner_q, resp_owner_d;
  logic [3:0] starve_cnt, starve_cnt_d;

  logic fetch_ok;
  logic starved;
  logic d_gnt;
  logic if_gnt;
  logic d_is_load;

  assign fetch_ok  = if_req && !if_flush;
  assign starved   = fetch_ok && (starve_cnt == LIMIT);
  assign d_is_load = (d_we == 4'b0000);

  // Grants are held off while reset is asserted so nothing reaches the memory.
  assign d_gnt  = !rst && d_req && !starved;
  assign if_gnt = !rst && fetch_ok && !d_gnt;

  assign d_ready  = d_gnt;
  assign if_ready = if_gnt;

  always_comb begin
    m_addr  = 32'h0;
    m_re    = 1'b0;
    m_we    = 4'b0000;
    m_wdata = 32'h0;
    if (d_gnt) begin
      m_addr  = d_addr;
      m_we    = d_we;
      m_wdata = d_wdata;
      m_re    = d_is_load;
    end else if (if_gnt) begin
      m_addr = if_addr;
      m_re   = 1'b1;
    end
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (if_gnt) begin
      resp_owner_d = OWN_FETCH;
    end else if (d_gnt && d_is_load) begin
      resp_owner_d = OWN_DATA;
    end
  end

  // Flush cycles with if_req still high leave the count untouched.
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (!if_req || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (fetch_ok && d_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt_d = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner_q <= OWN_NONE;
      starve_cnt   <= 4'd0;
    end else begin
      resp_owner_q <= resp_owner_d;
      starve_cnt   <= starve_cnt_d;
    end
  end

  assign if_rvalid = (resp_owner_q == OWN_FETCH) && !if_flush;
  assign d_rvalid  = (resp_owner_q == OWN_DATA);
  assign if_rdata  = m_rdata;
  assign d_rdata   = m_rdata;

  always_comb begin
    assert (!(if_gnt && d_gnt));
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with STARVE_LIMIT = 4.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] m_addr;
  logic        m_re;
  logic [3:0]  m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_ready (if_ready),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_addr   (m_addr),
    .m_re     (m_re),
    .m_we     (m_we),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0; d_we = 4'b0; d_wdata = 32'h0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; if_flush = 1'b0;
    d_req = 1'b1; d_addr = 32'h20; d_we = 4'b0; d_wdata = 32'h0; m_rdata = 32'h0;
    #1;
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready got %b want 0", if_ready); end
    n_checks++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready got %b want 0", d_ready); end
    n_checks++; if (m_re !== 1'b0 || m_we !== 4'b0) begin n_fail++; $display("FAIL reset_mem got re=%b we=%b want 0/0", m_re, m_we); end
    n_checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b/%b want 0/0", if_rvalid, d_rvalid); end
    step(); step();
    if_req = 1'b0; d_req = 1'b0;
    #2 rst = 1'b0;
    step();
    n_checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_rvalid got %b/%b want 0/0", if_rvalid, d_rvalid); end
    n_checks++; if (dut.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_starve_cnt got %0d want 0", dut.starve_cnt); end
  endtask

  task automatic test_fetch_only();
    idle();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_checks++; if (if_ready !== 1'b1 || d_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_grant got if=%b d=%b want 1/0", if_ready, d_ready); end
    n_checks++; if (m_re !== 1'b1 || m_addr !== 32'h100 || m_we !== 4'b0) begin n_fail++; $display("FAIL fetch_mem got re=%b addr=%h we=%b want 1/100/0", m_re, m_addr, m_we); end
    step();
    if_req = 1'b0; m_rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_resp got v=%b d=%h want 1/deadbeef", if_rvalid, if_rdata); end
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_resp_d_rvalid got %b want 0", d_rvalid); end
  endtask

  task automatic test_store_priority();
    idle();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 4'b1100; d_addr = 32'h202; d_wdata = 32'hABCD0000;
    #1;
    n_checks++; if (d_ready !== 1'b1 || if_ready !== 1'b0) begin n_fail++; $display("FAIL store_grant got d=%b if=%b want 1/0", d_ready, if_ready); end
    n_checks++; if (m_we !== 4'b1100 || m_re !== 1'b0 || m_addr !== 32'h202 || m_wdata !== 32'hABCD0000) begin
      n_fail++; $display("FAIL store_mem got we=%b re=%b addr=%h wd=%h want 1100/0/202/abcd0000", m_we, m_re, m_addr, m_wdata);
    end
    step();
    if_req = 1'b0; d_req = 1'b0; d_we = 4'b0;
    #1;
    n_checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_no_resp got %b/%b want 0/0", if_rvalid, d_rvalid); end
  endtask

  task automatic test_starvation();
    logic exp_f;
    idle();
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 4'b0; d_addr = 32'h400;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_f = (i == 4);
      n_checks++; if (if_ready !== exp_f || d_ready !== !exp_f) begin
        n_fail++; $display("FAIL starve_cycle%0d got if=%b d=%b want %b/%b", i, if_ready, d_ready, exp_f, !exp_f);
      end
      n_checks++; if (m_addr !== (exp_f ? 32'h300 : 32'h400) || m_re !== 1'b1) begin
        n_fail++; $display("FAIL starve_addr%0d got %h re=%b", i, m_addr, m_re);
      end
      if (i == 5) begin
        n_checks++; if (dut.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL starve_cnt_clear got %0d want 0", dut.starve_cnt); end
      end
      step();
    end
  endtask

  task automatic test_flush_hold();
    idle();
    if_req = 1'b1; if_addr = 32'h500; d_req = 1'b1; d_we = 4'b0; d_addr = 32'h600;
    step(); step();
    if_flush = 1'b1;
    #1;
    n_checks++; if (if_ready !== 1'b0 || d_ready !== 1'b1) begin n_fail++; $display("FAIL flush_data_grant got if=%b d=%b want 0/1", if_ready, d_ready); end
    step();
    if_flush = 1'b0;
    #1;
    n_checks++; if (dut.starve_cnt !== 4'd2) begin n_fail++; $display("FAIL flush_hold_cnt got %0d want 2", dut.starve_cnt); end
    if_req = 1'b0; d_req = 1'b0;
    step();
    n_checks++; if (dut.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL noreq_clear_cnt got %0d want 0", dut.starve_cnt); end
  endtask

  task automatic test_flush_kill();
    idle();
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL flushkill_grant got %b want 1", if_ready); end
    step();
    if_addr = 32'h80; if_flush = 1'b1; m_rdata = 32'h0BAD0BAD;
    #1;
    n_checks++; if (if_rvalid !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL flushkill_suppress got v=%b r=%b want 0/0", if_rvalid, if_ready); end
    step();
    if_flush = 1'b0;
    #1;
    n_checks++; if (if_ready !== 1'b1 || m_addr !== 32'h80 || if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL flushkill_refetch got r=%b addr=%h v=%b want 1/80/0", if_ready, m_addr, if_rvalid);
    end
    step();
    if_req = 1'b0; m_rdata = 32'h12345678;
    #1;
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h12345678) begin n_fail++; $display("FAIL flushkill_resp got v=%b d=%h want 1/12345678", if_rvalid, if_rdata); end
  endtask

  task automatic test_back_to_back();
    idle();
    d_req = 1'b1; d_we = 4'b0; d_addr = 32'h1001;
    #1;
    n_checks++; if (d_ready !== 1'b1 || m_addr !== 32'h1001) begin n_fail++; $display("FAIL b2b_beat0 got r=%b addr=%h want 1/1001", d_ready, m_addr); end
    step();
    d_addr = 32'h1004; m_rdata = 32'hAAAA1111;
    #1;
    n_checks++; if (d_ready !== 1'b1 || m_addr !== 32'h1004) begin n_fail++; $display("FAIL b2b_beat1 got r=%b addr=%h want 1/1004", d_ready, m_addr); end
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hAAAA1111) begin n_fail++; $display("FAIL b2b_resp0 got v=%b d=%h want 1/aaaa1111", d_rvalid, d_rdata); end
    step();
    d_req = 1'b0; m_rdata = 32'hBBBB2222;
    #1;
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hBBBB2222) begin n_fail++; $display("FAIL b2b_resp1 got v=%b d=%h want 1/bbbb2222", d_rvalid, d_rdata); end
    step();
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", d_rvalid); end
  endtask

  task automatic test_async_reset();
    idle();
    d_req = 1'b1; d_we = 4'b0; d_addr = 32'h700;
    step();
    d_req = 1'b0;
    #1;
    n_checks++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %b want 1", d_rvalid); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL arst_immediate got %b want 0", d_rvalid); end
    d_req = 1'b1; if_req = 1'b1;
    #1;
    n_checks++; if (d_ready !== 1'b0 || if_ready !== 1'b0 || m_re !== 1'b0) begin
      n_fail++; $display("FAIL arst_grants got d=%b if=%b re=%b want 0/0/0", d_ready, if_ready, m_re);
    end
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL arst_release got %b want 0", d_rvalid); end
    step();
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL arst_after got %b want 0", d_rvalid); end
    d_req = 1'b1; d_addr = 32'h704;
    step();
    d_req = 1'b0;
    #1;
    n_checks++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL arst_new_load got %b want 1", d_rvalid); end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_store_priority();
    test_starvation();
    test_flush_hold();
    test_flush_kill();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between instruction fetch and the execute stage's data port (loads, stores, and both beats of split misaligned accesses). Data requests normally win. A starvation counter guarantees forward progress for fetch, and a flush input discards fetch responses that are on the wrong path after a taken branch. The block sits between the fetch/execute stages and the synchronous-read memory, which has 1-cycle read latency.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles fetch may lose to data before it is forced a grant; legal range 1..15.
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — reset; asynchronous, active-high.
- `if_req`  in  1  — fetch request; held with `if_addr` until granted.
- `if_addr`  in  32  — fetch address; word-aligned.
- `if_flush`  in  1  — taken branch or redirect; kills fetch responses and fetch grants in this cycle.
- `if_ready`  out  1  — fetch granted this cycle.
- `if_rvalid`  out  1  — fetch read data valid this cycle.
- `if_rdata`  out  32  — fetch read data.
- `d_req`  in  1  — data request; held until granted.
- `d_addr`  in  32  — data address; per beat, already split by execute.
- `d_we`  in  4  — byte write enables; nonzero means store, zero means load.
- `d_wdata`  in  32  — store data, already lane-shifted.
- `d_ready`  out  1  — data granted this cycle.
- `d_rvalid`  out  1  — load data valid this cycle.
- `d_rdata`  out  32  — load data.
- `m_addr`  out  32  — memory address.
- `m_re`  out  1  — memory read strobe.
- `m_we`  out  4  — memory byte write enables.
- `m_wdata`  out  32  — memory write data.
- `m_rdata`  in  32  — memory read data; valid 1 cycle after `m_re`.

## Operation
**Grant decision (combinational).**
- `fetch_ok` = `if_req` && !`if_flush`.
- Data is granted if `d_req` && !(`fetch_ok` && `starve_cnt` == `STARVE_LIMIT`).
- Otherwise fetch is granted if `fetch_ok`.
- At most one grant per cycle.

**Memory drive.**
- On a data grant: `m_addr`=`d_addr`, `m_we`=`d_we`, `m_wdata`=`d_wdata`, `m_re`=(`d_we`==0).
- On a fetch grant: `m_addr`=`if_addr`, `m_re`=1, `m_we`=0.
- With no grant: `m_re`=0, `m_we`=0, `m_addr`/`m_wdata`=0.

**Response owner register (`resp_owner`: NONE / FETCH / DATA).**
- Loads FETCH on a fetch grant.
- Loads DATA on a data load grant.
- Loads NONE on a store grant or when nothing is granted.

**Responses.**
- `if_rvalid` = (`resp_owner`==FETCH) && !`if_flush`.
- `d_rvalid` = (`resp_owner`==DATA).
- `if_rdata` and `d_rdata` both pass `m_rdata` through; each is meaningful only while its rvalid is high.

**Starvation counter `starve_cnt` (4 bits).**
- Increments, saturating at `STARVE_LIMIT`, in cycles where `fetch_ok` && data is granted.
- Clears when fetch is granted or `if_req`==0.
- Holds otherwise, including cycles where `if_flush` is high with `if_req` still high.

**Stores** produce no response.

## Timing
- Grants are same-cycle combinational: a request seen in cycle N with ready=1 is accepted at edge N→N+1. Read data returns in cycle N+1.
- Full throughput: one grant per cycle, and back-to-back grants to the same or alternating requesters are allowed.
- Reset values, asserted asynchronously:
  - `resp_owner`=NONE, `starve_cnt`=0.
  - Hence `if_rvalid`=0 and `d_rvalid`=0.
  - While `rst` is high, `if_ready`, `d_ready`, `m_re` and `m_we` are forced to 0.
- Reset mid-response: the pending response is dropped and no rvalid is emitted after reset release.
- Simultaneous `if_flush` and a due fetch response: the response is suppressed and fetch is not granted that cycle. A data grant in the same cycle proceeds normally.
- Flush with no pending fetch: no effect beyond blocking the fetch grant.
- Requester protocol: `req`/`addr`/`we`/`wdata` must be held stable while ready=0. The arbiter does not latch them.

## Test plan
- **Fetch only:** `if_req`=1, `if_addr`=0x100 for 1 cycle → `if_ready`=1, `m_re`=1, `m_addr`=0x100; next cycle `m_rdata`=0xDEADBEEF → `if_rvalid`=1, `if_rdata`=0xDEADBEEF, `d_rvalid`=0.
- **Data store priority:** `if_req`=1 and `d_req`=1 with `d_we`=4'b1100, `d_addr`=0x202, `d_wdata`=0xABCD0000 → `d_ready`=1, `if_ready`=0, `m_we`=4'b1100, `m_re`=0; next cycle neither rvalid is high.
- **Starvation:** with `STARVE_LIMIT`=4, hold both requests high with data loads → data is granted for 4 cycles, fetch in cycle 5, then data again. The counter reads 0 after the fetch grant.
- **Flush kill:** grant fetch at 0x40 in cycle N, assert `if_flush` in cycle N+1 → `if_rvalid`=0 in N+1 and `if_ready`=0 in N+1. Fetch at 0x80 in N+2 returns normally in N+3.
- **Misaligned pair:** data load 0x1001 then 0x1004 on consecutive cycles → `d_ready`=1 both cycles and `d_rvalid`=1 in the two following cycles, each carrying that cycle's `m_rdata`.
- **Async reset:** assert `rst` between an edge and the next while `resp_owner`=DATA → `d_rvalid` drops to 0 immediately and stays 0 after release until a new load is granted.
